fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have imem_addr  output  32  fetch address, equal to the internal pc register.
REQ-006 SHALL have imem_valid  input  1  memory returns data for the imem_addr presented in the same cycle.
REQ-007 SHALL have imem_rdata  input  32  instruction word, qualified by imem_valid.
REQ-008 SHALL have stall  input  1  decode cannot accept a new instruction this cycle.
REQ-009 SHALL have branch_taken  input  1  redirect from execute; highest priority.
REQ-010 SHALL have branch_target  input  32  redirect address, qualified by branch_taken.
REQ-011 SHALL have if_valid  output  1  if_instr/if_pc hold a live instruction.
REQ-012 SHALL have if_pc  output  32  address of if_instr.
REQ-013 SHALL have if_instr  output  32  registered instruction to decode.
REQ-014 SHALL have opcode  output  7  if_instr[6:0], combinational, feeding the control unit; consumers gate with if_valid.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FULL, plus internal registers pc[31:0], buffer buf_instr[31:0], buf_pc[31:0].
REQ-016 IDLE: imem_req=0; unconditionally go to FETCH next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=pc.
REQ-018 FETCH, imem_valid=1, stall=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4; stay FETCH.
REQ-019 FETCH, imem_valid=1, stall=1: buf_instr<=imem_rdata, buf_pc<=pc, pc<=pc+4, output regs hold; go FULL.
REQ-020 FETCH, imem_valid=0, stall=0: if_valid<=0 (bubble); pc holds.
REQ-021 FETCH, imem_valid=0, stall=1: all registers hold.
REQ-022 FULL: imem_req=0; stall=1 holds everything; stall=0 loads if_instr/if_pc from buffer, if_valid<=1, go FETCH.
REQ-023 Branch: branch_taken=1 in any non-IDLE state SHALL pc<=branch_target, if_valid<=0, discard buffer and any same-cycle imem_valid response, go FETCH; overrides stall and REQ-018..022.
REQ-024 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-025 Latency SHALL be one cycle: response accepted at edge N appears on if_instr after edge N.
REQ-026 At most one instruction SHALL be buffered; imem_req SHALL never be 1 in FULL or IDLE.
REQ-027 branch_target low bits SHALL be used as given; no alignment masking.

Reset
REQ-028 rst_n=0 at an edge SHALL set state=IDLE, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), buffer cleared, regardless of state or concurrent branch/imem_valid.
REQ-029 During and the first cycle after reset, imem_req SHALL be 0; first request at imem_addr=RESET_PC in the second cycle after rst_n rises.

Verification
REQ-030 Reset release, imem_valid=1 every cycle, rdata=addr -> imem_addr 0,4,8; if_instr 0,4,8 one cycle later; if_valid=1 continuously.
REQ-031 stall=1 for 3 cycles while imem_valid=1 at pc=8 -> buffer takes 8, state FULL, imem_req=0, if_instr holds 4; stall drop -> if_instr=8 next cycle, fetch resumes at 12.
REQ-032 branch_taken=1, target=32'h100 same cycle as imem_valid at pc=12 -> response dropped, if_valid=0, next imem_addr=32'h100.
REQ-033 branch_taken=1 while FULL and stall=1 -> buffer discarded, if_valid=0, FETCH at target.
REQ-034 RESET_PC=32'hFFFF_FFFC, imem_valid=1 -> if_pc FFFF_FFFC then 0000_0000.
REQ-035 rst_n=0 mid-stall in FULL -> next cycle IDLE, if_valid=0, if_instr=32'h13, imem_req=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer between memory and decode.
// Latency: one cycle from accepted response to if_instr; stall backpressure parks one word, branch redirect wins.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  opcode
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: begin
                if (branch_taken)
                    w_next_state = S_FETCH;
                else if (imem_valid && stall)
                    w_next_state = S_FULL;
            end
            S_FULL: begin
                if (branch_taken || !stall)
                    w_next_state = S_FETCH;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        case (r_state)
            S_FETCH: imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // A redirect drops any response arriving in the same cycle as well as the parked word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_buf_instr <= 32'h0;
            r_buf_pc    <= 32'h0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'h0;
            r_if_instr  <= NOP;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (branch_taken) begin
                        r_pc       <= branch_target;
                        r_if_valid <= 1'b0;
                    end else if (imem_valid) begin
                        r_pc <= r_pc + 32'd4;
                        if (!stall) begin
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_pc;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_buf_instr <= imem_rdata;
                            r_buf_pc    <= r_pc;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (branch_taken) begin
                        r_pc        <= branch_target;
                        r_if_valid  <= 1'b0;
                        r_buf_instr <= 32'h0;
                        r_buf_pc    <= 32'h0;
                    end else if (!stall) begin
                        r_if_instr <= r_buf_instr;
                        r_if_pc    <= r_buf_pc;
                        r_if_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign opcode    = r_if_instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: two instances (default and wrapping RESET_PC) against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] salt = 32'h0;

    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] rdata [2];
    logic        ifv   [2];
    logic [31:0] ifpc  [2];
    logic [31:0] ifins [2];
    logic [6:0]  opc   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rdata[0] = addr[0] ^ salt;
    assign rdata[1] = addr[1] ^ salt;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_valid(imem_valid), .imem_rdata(rdata[0]), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(ifv[0]), .if_pc(ifpc[0]), .if_instr(ifins[0]), .opcode(opc[0])
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_valid(imem_valid), .imem_rdata(rdata[1]), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(ifv[1]), .if_pc(ifpc[1]), .if_instr(ifins[1]), .opcode(opc[1])
    );

    // Reference: a program counter, an optional parked word and the word presented to decode.
    logic [31:0] rpc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] m_pc [2];
    bit          m_idle [2];
    bit          m_held [2];
    logic [31:0] m_held_pc [2];
    logic [31:0] m_held_ins [2];
    bit          m_ifv [2];
    logic [31:0] m_ifpc [2];
    logic [31:0] m_ifins [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] word;
            word = m_pc[k] ^ salt;
            if (!rst_n) begin
                m_idle[k]  = 1'b1;
                m_pc[k]    = rpc[k];
                m_held[k]  = 1'b0;
                m_ifv[k]   = 1'b0;
                m_ifpc[k]  = 32'h0;
                m_ifins[k] = 32'h0000_0013;
            end else if (m_idle[k]) begin
                m_idle[k] = 1'b0;
            end else if (branch_taken) begin
                m_pc[k]   = branch_target;
                m_ifv[k]  = 1'b0;
                m_held[k] = 1'b0;
            end else if (m_held[k]) begin
                if (!stall) begin
                    m_ifins[k] = m_held_ins[k];
                    m_ifpc[k]  = m_held_pc[k];
                    m_ifv[k]   = 1'b1;
                    m_held[k]  = 1'b0;
                end
            end else if (imem_valid) begin
                if (!stall) begin
                    m_ifins[k] = word;
                    m_ifpc[k]  = m_pc[k];
                    m_ifv[k]   = 1'b1;
                end else begin
                    m_held_ins[k] = word;
                    m_held_pc[k]  = m_pc[k];
                    m_held[k]     = 1'b1;
                end
                m_pc[k] = m_pc[k] + 32'd4;
            end else if (!stall) begin
                m_ifv[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "d0" : "d1";
            check({p, ".imem_req"},  {31'h0, req[k]}, {31'h0, !m_idle[k] && !m_held[k]});
            check({p, ".imem_addr"}, addr[k], m_pc[k]);
            check({p, ".if_valid"},  {31'h0, ifv[k]}, {31'h0, m_ifv[k]});
            check({p, ".if_pc"},     ifpc[k], m_ifpc[k]);
            check({p, ".if_instr"},  ifins[k], m_ifins[k]);
            check({p, ".opcode"},    {25'h0, opc[k]}, {25'h0, m_ifins[k][6:0]});
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input bit b, input logic [31:0] t);
        @(negedge clk);
        rst_n         = r;
        imem_valid    = v;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        salt          = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 127) << 2);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        // reset with a concurrent branch and response that must be ignored
        step(0, 1, 0, 1, 32'h55);
        step(0, 1, 1, 0, 32'h0);
        // streaming, then a three-cycle stall parks one word
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        // redirect coincident with a response
        step(1, 1, 0, 1, 32'h100);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        // redirect while parked and stalled
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 1, 32'h203);
        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 32'h0);
        // reset while parked
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(0, 1, 1, 1, 32'h400);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
